// File: rtl/filter2d_pkg.sv
// Shared definitions for the parametrised 3x3 image filter: tap geometry,
// accumulator sizing and the frame-control FSM encoding.
package filter2d_pkg;

    localparam int NTAP = 9;
    localparam int CTAP = 4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Nine products of (DW+1) x CW bits need four extra bits of headroom.
    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + 5;
    endfunction

endpackage

// File: rtl/filter2d_linebuf.sv
// One-line pixel delay: read-before-write at the column address, so the
// returned value is the pixel written IMG_W steps earlier.
module filter2d_linebuf
    import filter2d_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:DEPTH-1];

    assign rdata = mem_r[addr];

    // Line storage; contents need no reset because row masking hides stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

endmodule

// File: rtl/filter2d_param.sv
// 3x3 signed convolution over a raster stream with zero-padded borders,
// programmable rounding shift, saturation and automatic end-of-frame flush.
module filter2d_param
    import filter2d_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int SW    = 4
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          i_strb,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_strb,
    output logic [DW-1:0] o_data,
    input  logic          h_write,
    input  logic [3:0]    h_idx,
    input  logic [CW-1:0] h_data,
    input  logic [SW-1:0] cfg_shift
);

    localparam int CLW   = $clog2(IMG_W);
    localparam int RWW   = $clog2(IMG_H + 2);
    localparam int ACC_W = acc_width(DW, CW);
    localparam int PW    = DW + CW + 1;

    localparam logic [CLW-1:0] COL_LAST = CLW'(IMG_W - 1);
    localparam logic [CLW-1:0] COL_ONE  = CLW'(1);
    localparam logic [RWW-1:0] ROW_LAST = RWW'(IMG_H - 1);
    localparam logic [RWW-1:0] ROW_END  = RWW'(IMG_H + 1);
    localparam logic [RWW-1:0] ROW_ONE  = RWW'(1);
    localparam logic [RWW-1:0] ROW_TWO  = RWW'(2);
    localparam logic [SW-1:0]  SH_ONE   = SW'(1);

    localparam logic signed [CW-1:0]    COEF_ONE  = CW'(1);
    localparam logic signed [CW-1:0]    COEF_ZERO = CW'(0);
    localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((1 << DW) - 1);

    localparam int M_TOP   = 0;
    localparam int M_BOT   = 1;
    localparam int M_LEFT  = 2;
    localparam int M_RIGHT = 3;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CLW-1:0]       col_r;
    logic [RWW-1:0]       row_r;
    logic                 step_s;
    logic [DW-1:0]        pix_s;
    logic [DW-1:0]        lb0_s;
    logic [DW-1:0]        lb1_s;

    logic                 trig_s;
    logic [RWW-1:0]       crow_s;
    logic [CLW-1:0]       ccol_s;

    logic [DW-1:0]        win_r [0:2][0:2];
    logic [3:0]           mask_r;
    logic                 v1_r;

    logic signed [CW-1:0] coef_r [0:NTAP-1];
    logic [DW-1:0]        tap_s  [0:NTAP-1];
    logic signed [PW-1:0] prod_s [0:NTAP-1];
    logic signed [PW-1:0] prod_r [0:NTAP-1];
    logic                 v2_r;

    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] sum_r;
    logic                    v3_r;

    logic signed [ACC_W-1:0] rnd_add_s;
    logic signed [ACC_W-1:0] rnd_s;
    logic signed [ACC_W-1:0] shr_s;
    logic [DW-1:0]           sat_s;

    // FSM state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: enter FLUSH on the last pixel, leave after the final pseudo-pixel.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (i_strb && (col_r == COL_LAST) && (row_r == ROW_LAST)) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (row_r == ROW_END) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs: a step is a real transfer in RUN or a zero pseudo-pixel in FLUSH.
    always_comb begin
        i_ready = 1'b0;
        step_s  = 1'b0;
        pix_s   = '0;
        case (state_r)
            ST_RUN: begin
                i_ready = 1'b1;
                step_s  = i_strb;
                pix_s   = i_data;
            end
            ST_FLUSH: begin
                i_ready = 1'b0;
                step_s  = 1'b1;
                pix_s   = '0;
            end
            default: begin
                i_ready = 1'b0;
                step_s  = 1'b0;
                pix_s   = '0;
            end
        endcase
    end

    // Raster position of the pixel being stepped in; FLUSH walks rows IMG_H and IMG_H+1.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            col_r <= '0;
            row_r <= '0;
        end else if (step_s) begin
            if ((state_r == ST_FLUSH) && (row_r == ROW_END)) begin
                col_r <= '0;
                row_r <= '0;
            end else if (col_r == COL_LAST) begin
                col_r <= '0;
                row_r <= row_r + ROW_ONE;
            end else begin
                col_r <= col_r + COL_ONE;
            end
        end
    end

    filter2d_linebuf #(.DW(DW), .DEPTH(IMG_W), .AW(CLW)) u_lb0 (
        .clk   (clk),
        .we    (step_s),
        .addr  (col_r),
        .wdata (pix_s),
        .rdata (lb0_s)
    );

    filter2d_linebuf #(.DW(DW), .DEPTH(IMG_W), .AW(CLW)) u_lb1 (
        .clk   (clk),
        .we    (step_s),
        .addr  (col_r),
        .wdata (lb0_s),
        .rdata (lb1_s)
    );

    // Window centre lags the incoming pixel by IMG_W+1 raster positions.
    always_comb begin
        trig_s = 1'b0;
        crow_s = '0;
        ccol_s = '0;
        if (col_r == '0) begin
            crow_s = row_r - ROW_TWO;
            ccol_s = COL_LAST;
            trig_s = (row_r >= ROW_TWO);
        end else begin
            crow_s = row_r - ROW_ONE;
            ccol_s = col_r - COL_ONE;
            trig_s = (row_r >= ROW_ONE);
        end
    end

    // S1: shift the 3x3 window and latch which border taps must read as zero.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v1_r   <= 1'b0;
            mask_r <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_r[r][c] <= '0;
                end
            end
        end else begin
            v1_r <= step_s & trig_s;
            if (step_s) begin
                for (int r = 0; r < 3; r++) begin
                    win_r[r][0] <= win_r[r][1];
                    win_r[r][1] <= win_r[r][2];
                end
                win_r[0][2]     <= lb1_s;
                win_r[1][2]     <= lb0_s;
                win_r[2][2]     <= pix_s;
                mask_r[M_TOP]   <= (crow_s == '0);
                mask_r[M_BOT]   <= (crow_s == ROW_LAST);
                mask_r[M_LEFT]  <= (ccol_s == '0);
                mask_r[M_RIGHT] <= (ccol_s == COL_LAST);
            end
        end
    end

    // Coefficient bank; identity kernel out of reset, indices above 8 never match.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int k = 0; k < NTAP; k++) begin
                coef_r[k] <= (k == CTAP) ? COEF_ONE : COEF_ZERO;
            end
        end else if (h_write) begin
            for (int k = 0; k < NTAP; k++) begin
                if (h_idx == 4'(k)) begin
                    coef_r[k] <= h_data;
                end
            end
        end
    end

    // Border masking and signed multiply of zero-extended pixels.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((r == 0 && mask_r[M_TOP]) || (r == 2 && mask_r[M_BOT]) ||
                    (c == 0 && mask_r[M_LEFT]) || (c == 2 && mask_r[M_RIGHT])) begin
                    tap_s[r*3+c] = '0;
                end else begin
                    tap_s[r*3+c] = win_r[r][c];
                end
            end
        end
        for (int k = 0; k < NTAP; k++) begin
            prod_s[k] = $signed({{(PW-DW){1'b0}}, tap_s[k]}) *
                        $signed({{(PW-CW){coef_r[k][CW-1]}}, coef_r[k]});
        end
    end

    // S2: product register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v2_r <= 1'b0;
            for (int k = 0; k < NTAP; k++) begin
                prod_r[k] <= '0;
            end
        end else begin
            v2_r <= v1_r;
            for (int k = 0; k < NTAP; k++) begin
                prod_r[k] <= prod_s[k];
            end
        end
    end

    // Adder tree over sign-extended products.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NTAP; k++) begin
            sum_s = sum_s + $signed({{(ACC_W-PW){prod_r[k][PW-1]}}, prod_r[k]});
        end
    end

    // S3: accumulator register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v3_r  <= 1'b0;
            sum_r <= '0;
        end else begin
            v3_r  <= v2_r;
            sum_r <= sum_s;
        end
    end

    // Round half toward +inf, arithmetic shift, clamp to the pixel range.
    always_comb begin
        rnd_add_s = '0;
        if (cfg_shift != '0) begin
            rnd_add_s = ACC_ONE << (cfg_shift - SH_ONE);
        end else begin
            rnd_add_s = '0;
        end
        rnd_s = sum_r + rnd_add_s;
        shr_s = rnd_s >>> cfg_shift;
        if (shr_s[ACC_W-1]) begin
            sat_s = '0;
        end else if (shr_s > SAT_MAX) begin
            sat_s = '1;
        end else begin
            sat_s = shr_s[DW-1:0];
        end
    end

    // S4: registered output pixel; o_data holds between strobes.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            o_strb <= 1'b0;
            o_data <= '0;
        end else begin
            o_strb <= v3_r;
            if (v3_r) begin
                o_data <= sat_s;
            end
        end
    end

endmodule

// File: tb/tb_filter2d_param.sv
// Directed bench for filter2d_param on an 8x4 image: identity, box, saturation,
// flush handshake, back-to-back frames, sparse input and mid-frame reset.
module tb_filter2d_param;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int SW = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          i_strb;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          o_strb;
    logic [DW-1:0] o_data;
    logic          h_write;
    logic [3:0]    h_idx;
    logic [CW-1:0] h_data;
    logic [SW-1:0] cfg_shift;

    int errors = 0;
    int checks = 0;
    int pcyc   = 0;
    int xfer11_cyc = 0;

    logic [7:0] outq [$];
    int         outc [$];

    int img_m  [0:H-1][0:W-1];
    int coef_m [0:8];
    int shift_m;

    always #5 clk = ~clk;

    filter2d_param #(.DW(DW), .CW(CW), .IMG_W(W), .IMG_H(H), .SW(SW)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .i_strb    (i_strb),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .o_strb    (o_strb),
        .o_data    (o_data),
        .h_write   (h_write),
        .h_idx     (h_idx),
        .h_data    (h_data),
        .cfg_shift (cfg_shift)
    );

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin
        if (o_strb === 1'b1) begin
            outq.push_back(o_data);
            outc.push_back(pcyc);
        end
    end

    function automatic int ref_out(input int r, input int c);
        int s;
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
                    s += img_m[r+dr][c+dc] * coef_m[(dr+1)*3 + (dc+1)];
            end
        end
        if (shift_m > 0) s += (1 << (shift_m - 1));
        s = s >>> shift_m;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic do_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) coef_m[k] = (k == 4) ? 1 : 0;
    endtask

    task automatic set_coef(input int k, input int v);
        h_write = 1'b1;
        h_idx   = k[3:0];
        h_data  = v[7:0];
        @(negedge clk);
        h_write = 1'b0;
        if (k <= 8) coef_m[k] = v;
    endtask

    task automatic drive_pixel(input int d, output int waited);
        int dv;
        dv = d;
        waited = 0;
        while (i_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        i_strb = 1'b1;
        i_data = dv[7:0];
        @(negedge clk);
    endtask

    task automatic send_frame(input int gap, input bit hold, output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < N; i++) begin
            if (i == W + 1) xfer11_cyc = pcyc;
            drive_pixel(img_m[i / W][i % W], w);
            if (i == 0) first_wait = w;
            if (gap > 0) begin
                i_strb = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        if (!hold) i_strb = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int k;
        k = 0;
        while (outq.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_strb !== 1'b0) begin errors++; $display("FAIL reset_o_strb: got %b want 0", o_strb); end
        checks++;
        if (o_data !== 8'd0) begin errors++; $display("FAIL reset_o_data: got %0d want 0", o_data); end
        checks++;
        if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
    endtask

    task automatic test_identity();
        int fw;
        cfg_shift = 4'd0;
        shift_m = 0;
        for (int i = 0; i < N; i++) img_m[i / W][i % W] = i;
        outq.delete(); outc.delete();
        send_frame(0, 1'b0, fw);
        wait_drain(N);
        checks++;
        if (outq.size() != N) begin errors++; $display("FAIL identity_count: got %0d want %0d", outq.size(), N); end
        for (int i = 0; i < N && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== 8'(i)) begin errors++; $display("FAIL identity_px%0d: got %0d want %0d", i, outq[i], i); end
        end
        if (outc.size() > 0) begin
            checks++;
            if (outc[0] - xfer11_cyc != 4) begin
                errors++; $display("FAIL identity_latency: got %0d want 4", outc[0] - xfer11_cyc);
            end
        end
    endtask

    task automatic test_box();
        int fw;
        int e;
        bit er;
        bit ec;
        for (int k = 0; k < 9; k++) set_coef(k, 1);
        cfg_shift = 4'd3;
        shift_m = 3;
        for (int i = 0; i < N; i++) img_m[i / W][i % W] = 100;
        outq.delete(); outc.delete();
        send_frame(0, 1'b0, fw);
        wait_drain(N);
        checks++;
        if (outq.size() != N) begin errors++; $display("FAIL box_count: got %0d want %0d", outq.size(), N); end
        for (int i = 0; i < N && i < outq.size(); i++) begin
            er = (i / W == 0) || (i / W == H - 1);
            ec = (i % W == 0) || (i % W == W - 1);
            e  = (er && ec) ? 50 : ((er || ec) ? 75 : 113);
            checks++;
            if (outq[i] !== 8'(e)) begin errors++; $display("FAIL box_px%0d: got %0d want %0d", i, outq[i], e); end
        end
    endtask

    task automatic test_saturation();
        int fw;
        for (int k = 0; k < 9; k++) set_coef(k, (k == 4) ? 4 : 0);
        cfg_shift = 4'd0;
        shift_m = 0;
        for (int i = 0; i < N; i++) img_m[i / W][i % W] = 255;
        outq.delete(); outc.delete();
        send_frame(0, 1'b0, fw);
        wait_drain(N);
        checks++;
        if (outq.size() != N) begin errors++; $display("FAIL sat_hi_count: got %0d want %0d", outq.size(), N); end
        for (int i = 0; i < N && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== 8'd255) begin errors++; $display("FAIL sat_hi_px%0d: got %0d want 255", i, outq[i]); end
        end
        set_coef(4, -1);
        outq.delete(); outc.delete();
        send_frame(0, 1'b0, fw);
        wait_drain(N);
        checks++;
        if (outq.size() != N) begin errors++; $display("FAIL sat_lo_count: got %0d want %0d", outq.size(), N); end
        for (int i = 0; i < N && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== 8'd0) begin errors++; $display("FAIL sat_lo_px%0d: got %0d want 0", i, outq[i]); end
        end
    endtask

    task automatic load_edge_kernel();
        set_coef(0, -1); set_coef(1, 0);  set_coef(2, 1);
        set_coef(3, -2); set_coef(4, 5);  set_coef(5, 2);
        set_coef(6, 1);  set_coef(7, -3); set_coef(8, -1);
        cfg_shift = 4'd1;
        shift_m = 1;
        for (int i = 0; i < N; i++) img_m[i / W][i % W] = (i * 53 + (i % W) * 29 + 7) % 256;
    endtask

    task automatic test_back_to_back();
        int fw;
        int e;
        load_edge_kernel();
        outq.delete(); outc.delete();
        for (int f = 0; f < 3; f++) begin
            send_frame(0, (f < 2), fw);
            if (f > 0) begin
                checks++;
                if (fw != W + 1) begin errors++; $display("FAIL flush_ready_low_f%0d: got %0d want %0d", f, fw, W + 1); end
            end
        end
        wait_drain(3 * N);
        checks++;
        if (outq.size() != 3 * N) begin errors++; $display("FAIL b2b_count: got %0d want %0d", outq.size(), 3 * N); end
        for (int i = 0; i < 3 * N && i < outq.size(); i++) begin
            e = ref_out((i % N) / W, i % W);
            checks++;
            if (outq[i] !== 8'(e)) begin errors++; $display("FAIL b2b_px%0d: got %0d want %0d", i, outq[i], e); end
        end
    endtask

    task automatic test_sparse();
        int fw;
        int e;
        outq.delete(); outc.delete();
        send_frame(16, 1'b0, fw);
        wait_drain(N);
        checks++;
        if (outq.size() != N) begin errors++; $display("FAIL sparse_count: got %0d want %0d", outq.size(), N); end
        for (int i = 0; i < N && i < outq.size(); i++) begin
            e = ref_out(i / W, i % W);
            checks++;
            if (outq[i] !== 8'(e)) begin errors++; $display("FAIL sparse_px%0d: got %0d want %0d", i, outq[i], e); end
        end
    endtask

    task automatic test_reset_midframe();
        int fw;
        int w;
        cfg_shift = 4'd0;
        shift_m = 0;
        for (int i = 0; i < 13; i++) drive_pixel(200 - i, w);
        i_strb = 1'b0;
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        outq.delete(); outc.delete();
        n_reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) coef_m[k] = (k == 4) ? 1 : 0;
        checks++;
        if (o_strb !== 1'b0) begin errors++; $display("FAIL midrst_o_strb: got %b want 0", o_strb); end
        set_coef(9, 7);
        set_coef(15, 3);
        repeat (10) @(negedge clk);
        checks++;
        if (outq.size() != 0) begin errors++; $display("FAIL midrst_stale: got %0d want 0", outq.size()); end
        for (int i = 0; i < N; i++) img_m[i / W][i % W] = 3 * i + 1;
        outq.delete(); outc.delete();
        send_frame(0, 1'b0, fw);
        wait_drain(N);
        checks++;
        if (outq.size() != N) begin errors++; $display("FAIL midrst_count: got %0d want %0d", outq.size(), N); end
        for (int i = 0; i < N && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== 8'(3 * i + 1)) begin errors++; $display("FAIL midrst_px%0d: got %0d want %0d", i, outq[i], 3 * i + 1); end
        end
    endtask

    initial begin
        n_reset   = 1'b0;
        i_strb    = 1'b0;
        i_data    = 8'd0;
        h_write   = 1'b0;
        h_idx     = 4'd0;
        h_data    = 8'd0;
        cfg_shift = 4'd0;
        shift_m   = 0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_box();
        test_saturation();
        test_back_to_back();
        test_sparse();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
